scale_cfg_ctrl: RTL

SCALE_CFG_CTRL -- requirements
Module: scale_cfg_ctrl

---
 rtl/scale_pkg.sv | 43 ++++
 rtl/scale_div_serial.sv | 79 +++++++
 rtl/scale_cfg_ctrl.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/scale_pkg.sv
// Shared types and constants for the scaler configuration controller:
// controller state encoding, geometry bundle and power-on geometry/scale values.
package scale_pkg;

    localparam int DIM_W = 12;
    localparam int DIV_W = 20;
    localparam int K_W   = 16;

    localparam logic [DIM_W-1:0] RST_S_WIDTH  = 12'd1920;
    localparam logic [DIM_W-1:0] RST_S_HEIGHT = 12'd1080;
    localparam logic [DIM_W-1:0] RST_T_WIDTH  = 12'd1920;
    localparam logic [DIM_W-1:0] RST_T_HEIGHT = 12'd1080;
    localparam logic [K_W-1:0]   RST_SCALE_K  = 16'h0100;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DIV_H   = 2'd1,
        ST_DIV_V   = 2'd2,
        ST_WAIT_VS = 2'd3
    } scale_state_e;

    typedef struct packed {
        logic [DIM_W-1:0] s_width;
        logic [DIM_W-1:0] s_height;
        logic [DIM_W-1:0] t_width;
        logic [DIM_W-1:0] t_height;
    } geom_t;

    localparam geom_t RST_GEOM = '{
        s_width:  RST_S_WIDTH,
        s_height: RST_S_HEIGHT,
        t_width:  RST_T_WIDTH,
        t_height: RST_T_HEIGHT
    };

    // Zero dimensions and any upscale are not representable by the scaler.
    function automatic logic cfg_invalid(input geom_t g);
        return (g.s_width == '0) || (g.s_height == '0) ||
               (g.t_width == '0) || (g.t_height == '0) ||
               (g.t_width > g.s_width) || (g.t_height > g.s_height);
    endfunction

endpackage

// File: rtl/scale_div_serial.sv
// Serial restoring divider: 20-bit dividend / 12-bit divisor, one quotient bit
// per clock, 20 clocks per division; start performs the first step.
module scale_div_serial
    import scale_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [DIV_W-1:0] dividend_i,
    input  logic [DIM_W-1:0] divisor_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [K_W-1:0]   quotient_o,
    output logic             ovf_o
);

    localparam logic [4:0] CNT_LOAD = 5'(DIV_W - 1);

    logic [DIM_W-1:0] rem_q;
    logic [DIM_W-1:0] rem_d;
    logic [DIM_W-1:0] divisor_q;
    logic [DIM_W-1:0] src_rem;
    logic [DIM_W-1:0] src_div;
    logic [DIM_W-1:0] diff;
    logic [DIV_W-1:0] quo_q;
    logic [DIV_W-1:0] quo_d;
    logic [DIV_W-1:0] src_quo;
    logic [DIM_W:0]   trial;
    logic             ge;
    logic [4:0]       cnt_q;
    logic             busy_q;
    logic             done_q;

    // quo_q shifts the dividend out at the top while quotient bits enter at the bottom.
    always_comb begin
        src_rem = start_i ? '0 : rem_q;
        src_quo = start_i ? dividend_i : quo_q;
        src_div = start_i ? divisor_i : divisor_q;
        trial   = {src_rem, src_quo[DIV_W-1]};
        ge      = trial >= {1'b0, src_div};
        diff    = trial[DIM_W-1:0] - src_div;
        rem_d   = ge ? diff : trial[DIM_W-1:0];
        quo_d   = {src_quo[DIV_W-2:0], ge};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rem_q     <= '0;
            quo_q     <= '0;
            divisor_q <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start_i) begin
                rem_q     <= rem_d;
                quo_q     <= quo_d;
                divisor_q <= divisor_i;
                cnt_q     <= CNT_LOAD;
                busy_q    <= 1'b1;
            end else if (busy_q) begin
                rem_q <= rem_d;
                quo_q <= quo_d;
                cnt_q <= cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign quotient_o = quo_q[K_W-1:0];
    assign ovf_o      = |quo_q[DIV_W-1:K_W];

endmodule

// File: rtl/scale_cfg_ctrl.sv
// Scaler configuration controller: validates a requested geometry, computes the
// Q8.8 scale factors and applies everything atomically on the next vs edge.
module scale_cfg_ctrl
    import scale_pkg::*;
#(
    parameter int   FRAC_BITS = 8,
    parameter logic VS_POL    = 1'b1
) (
    input  logic             pixel_clk,
    input  logic             sys_rst,
    input  logic             vs,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [DIM_W-1:0] cfg_s_width,
    input  logic [DIM_W-1:0] cfg_s_height,
    input  logic [DIM_W-1:0] cfg_t_width,
    input  logic [DIM_W-1:0] cfg_t_height,
    output logic [DIM_W-1:0] s_width,
    output logic [DIM_W-1:0] s_height,
    output logic [DIM_W-1:0] t_width,
    output logic [DIM_W-1:0] t_height,
    output logic [K_W-1:0]   h_scale_k,
    output logic [K_W-1:0]   v_scale_k,
    output logic             scale_rst,
    output logic             cfg_done,
    output logic             cfg_err
);

    scale_state_e     state_q;
    geom_t            cfg_in;
    geom_t            shadow_q;
    geom_t            active_q;
    logic [K_W-1:0]   h_k_shadow_q;
    logic [K_W-1:0]   v_k_shadow_q;
    logic [K_W-1:0]   h_k_q;
    logic [K_W-1:0]   v_k_q;
    logic             cfg_ready_q;
    logic             scale_rst_q;
    logic             cfg_done_q;
    logic             cfg_err_q;
    logic             vs_d_q;
    logic             wait_arm_q;

    logic             chk_cycle;
    logic             cfg_bad;
    logic             v_phase;
    logic             vs_edge;
    logic             div_start;
    logic             div_busy;
    logic             div_done;
    logic             div_ovf;
    logic [DIV_W-1:0] div_dividend;
    logic [DIM_W-1:0] div_divisor;
    logic [K_W-1:0]   div_quo;

    assign cfg_in = {cfg_s_width, cfg_s_height, cfg_t_width, cfg_t_height};

    // The first DIV_H cycle (divider idle, no result) is the validation slot; the
    // V division is launched on the same edge that retires the H result.
    always_comb begin
        chk_cycle    = (state_q == ST_DIV_H) && !div_busy && !div_done;
        cfg_bad      = cfg_invalid(shadow_q);
        v_phase      = (state_q == ST_DIV_H) && div_done;
        div_start    = (chk_cycle && !cfg_bad) || (v_phase && !div_ovf);
        div_dividend = v_phase ? ({{(DIV_W-DIM_W){1'b0}}, shadow_q.s_height} << FRAC_BITS)
                               : ({{(DIV_W-DIM_W){1'b0}}, shadow_q.s_width}  << FRAC_BITS);
        div_divisor  = v_phase ? shadow_q.t_height : shadow_q.t_width;
        vs_edge      = (vs == VS_POL) && (vs_d_q != VS_POL);
    end

    scale_div_serial u_div (
        .clk_i      (pixel_clk),
        .rst_i      (sys_rst),
        .start_i    (div_start),
        .dividend_i (div_dividend),
        .divisor_i  (div_divisor),
        .busy_o     (div_busy),
        .done_o     (div_done),
        .quotient_o (div_quo),
        .ovf_o      (div_ovf)
    );

    // Handshake: a configuration transfers on any edge where cfg_valid and
    // cfg_ready are both high; cfg_ready is high only while idle, and the
    // requester keeps cfg_valid and the fields stable until that edge.
    always_ff @(posedge pixel_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q      <= ST_IDLE;
            cfg_ready_q  <= 1'b0;
            shadow_q     <= RST_GEOM;
            active_q     <= RST_GEOM;
            h_k_shadow_q <= RST_SCALE_K;
            v_k_shadow_q <= RST_SCALE_K;
            h_k_q        <= RST_SCALE_K;
            v_k_q        <= RST_SCALE_K;
            scale_rst_q  <= 1'b0;
            cfg_done_q   <= 1'b0;
            cfg_err_q    <= 1'b0;
            vs_d_q       <= ~VS_POL;
            wait_arm_q   <= 1'b0;
        end else begin
            vs_d_q      <= vs;
            scale_rst_q <= 1'b0;
            cfg_done_q  <= 1'b0;
            cfg_err_q   <= 1'b0;
            cfg_ready_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cfg_valid && cfg_ready_q) begin
                        shadow_q <= cfg_in;
                        state_q  <= ST_DIV_H;
                    end else begin
                        cfg_ready_q <= 1'b1;
                    end
                end
                ST_DIV_H: begin
                    if (chk_cycle) begin
                        if (cfg_bad) begin
                            cfg_err_q   <= 1'b1;
                            cfg_ready_q <= 1'b1;
                            state_q     <= ST_IDLE;
                        end
                    end else if (div_done) begin
                        if (div_ovf) begin
                            cfg_err_q   <= 1'b1;
                            cfg_ready_q <= 1'b1;
                            state_q     <= ST_IDLE;
                        end else begin
                            h_k_shadow_q <= div_quo;
                            state_q      <= ST_DIV_V;
                        end
                    end
                end
                ST_DIV_V: begin
                    if (div_done) begin
                        if (div_ovf) begin
                            cfg_err_q   <= 1'b1;
                            cfg_ready_q <= 1'b1;
                            state_q     <= ST_IDLE;
                        end else begin
                            v_k_shadow_q <= div_quo;
                            wait_arm_q   <= 1'b0;
                            state_q      <= ST_WAIT_VS;
                        end
                    end
                end
                ST_WAIT_VS: begin
                    // An edge seen in the very first WAIT_VS cycle belongs to the
                    // frame already in flight, so it is not used for the apply.
                    wait_arm_q <= 1'b1;
                    if (wait_arm_q && vs_edge) begin
                        active_q    <= shadow_q;
                        h_k_q       <= h_k_shadow_q;
                        v_k_q       <= v_k_shadow_q;
                        scale_rst_q <= 1'b1;
                        cfg_done_q  <= 1'b1;
                        cfg_ready_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    cfg_ready_q <= 1'b1;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign cfg_ready = cfg_ready_q;
    assign s_width   = active_q.s_width;
    assign s_height  = active_q.s_height;
    assign t_width   = active_q.t_width;
    assign t_height  = active_q.t_height;
    assign h_scale_k = h_k_q;
    assign v_scale_k = v_k_q;
    assign scale_rst = scale_rst_q;
    assign cfg_done  = cfg_done_q;
    assign cfg_err   = cfg_err_q;

endmodule
